muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
- Iterative multiply/divide sequencer that owns the HI/LO register pair for the multi-cycle CPU.
- Takes operands from the A/B register outputs and runs a radix-2 shift-add multiply or restoring divide over WIDTH cycles.
- Signals busy to the control unit, which holds the FSM in its wait state until done.
- Replaces the single-cycle combinational product/quotient path into HI/LO.

Parameters:
WIDTH, 32, operand width; iteration count equals WIDTH

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high; clears all state
start  input  1  request strobe, sampled only in IDLE
op  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6-7=no-op
a  input  WIDTH  multiplicand/dividend/move source (rs)
b  input  WIDTH  multiplier/divisor (rt)
abort  input  1  cancel in-flight operation (exception flush)
busy  output  1  operation in flight; CU must not issue start, mfhi or mflo
done  output  1  one-cycle pulse; hi/lo hold the new result this cycle
div_zero  output  1  sticky flag from last DIV/DIVU; 1 when divisor was 0
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset: state=IDLE; busy=0, done=0, div_zero=0, hi=0, lo=0, counter=0. Reset wins over start and abort in the same cycle.
- States: IDLE, RUN, FIX.
- IDLE, start=1, op in 0-3, sampled at edge k:
  - Latch |a| and |b| (signed ops) or raw a and b (unsigned ops); latch the sign bits and op.
  - Clear the accumulator; counter=0; go to RUN.
- IDLE, start=1, op=4/5: hi<=a or lo<=a at edge k. No busy, no done, state stays IDLE.
- IDLE, start=1, op=6/7: ignored.
- IDLE, start=0: hold.
- RUN (cycles k+1 .. k+WIDTH), one step per cycle:
  - Multiply: if multiplier LSB=1, add multiplicand to the upper half; shift the 2*WIDTH accumulator right 1, capturing the carry.
  - Divide: shift {rem,quot} left 1; trial subtract divisor from rem; if non-negative, commit and set quot LSB=1.
  - counter increments; after the step with counter=WIDTH-1, go to FIX.
- FIX (cycle k+WIDTH+1):
  - MULT: negate the 2*WIDTH product if sign(a)!=sign(b). {hi,lo} = product (hi = upper half).
  - DIV/DIVU: lo=quotient, hi=remainder. Signed: quotient negated if signs differ; remainder takes the sign of the dividend.
  - hi/lo are written at the end of the FIX cycle; go to IDLE.
- Timing, start sampled at edge k:
  - busy=1 in cycles k+1 .. k+WIDTH+1.
  - Cycle k+WIDTH+2: busy=0, done=1, new hi/lo visible. Latency is WIDTH+2 = 34 cycles for WIDTH=32.
- done is registered and high exactly one cycle. A back-to-back start can be accepted in the done cycle.
- Divide by zero (b==0 at latch):
  - Full latency still runs; done pulses normally.
  - hi and lo are NOT updated; div_zero=1.
  - div_zero clears when the next DIV/DIVU with b!=0 completes. MULT, MULTU and moves leave it unchanged.
- Overflow case DIV -2^(WIDTH-1) / -1: quotient wraps to 0x80000000, remainder 0, no flag.
- start while busy: ignored, with no queueing.
- abort:
  - In RUN or FIX: return to IDLE next edge; hi/lo unchanged; no done; div_zero unchanged.
  - In IDLE: no effect, and same-cycle start is dropped.
- Inputs a and b are only sampled at acceptance; later changes have no effect.
- hi/lo always reflect the last committed value; partial results are never exposed.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> busy cycles 1-33; done at cycle 34; hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=0xFFFFFFFD (-3) b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then MULT 0x80000000*0x80000000 -> hi=0x40000000, lo=0.
- DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 -> lo=14, hi=2. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI a=0x12345678, then DIVU 5/0 -> done at cycle 34, div_zero=1, hi stays 0x12345678. Then DIVU 9/3 -> div_zero=0, lo=3, hi=0.
- Protocol:
  - start MULTU 3*4; re-assert start with DIVU in cycle 10 -> ignored; result hi=0, lo=12.
  - start DIV; abort at cycle 15 -> busy=0 at cycle 16, no done, hi/lo unchanged.
  - reset asserted at cycle 20 of a MULT -> all outputs 0 next cycle.
- Back-to-back: new start asserted in the done cycle of a MULTU -> accepted; second done exactly 34 cycles later.

Source files
------------

// File: rtl/muldiv_seq_if.sv
// rtl/muldiv_seq_if.sv - control-unit request/response bundle for the HI/LO multiply/divide sequencer
interface muldiv_seq_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             abort;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, abort,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b, abort,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - iterative radix-2 multiply / restoring divide sequencer owning HI/LO
// Works on magnitudes; signs are reapplied in FIX so hi/lo only ever see finished results.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         reset,
  muldiv_seq_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state;
  logic [WIDTH-1:0]   opb;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      counter;
  logic               sign_a;
  logic               sign_b;
  logic               is_div;
  logic               is_signed;
  logic               b_zero;

  logic               req_signed;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     shl_rem;
  logic [WIDTH-1:0]   sub_rem;
  logic               rem_ge;
  logic [2*WIDTH-1:0] acc_next;
  logic               neg_result;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;

  always_comb begin
    req_signed = ~bus.op[0];
    a_mag      = (req_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    b_mag      = (req_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;

    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opb};
    // Remainder after the left shift can need one extra bit; the subtract result never does.
    shl_rem = acc[2*WIDTH-1:WIDTH-1];
    rem_ge  = (shl_rem >= {1'b0, opb});
    sub_rem = shl_rem[WIDTH-1:0] - opb;

    if (is_div) begin
      if (rem_ge) acc_next = {sub_rem, acc[WIDTH-2:0], 1'b1};
      else        acc_next = {shl_rem[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end else if (acc[0]) begin
      acc_next = {mul_sum, acc[WIDTH-1:1]};
    end else begin
      acc_next = {1'b0, acc[2*WIDTH-1:1]};
    end

    neg_result = is_signed && (sign_a ^ sign_b);
    prod_fix   = neg_result ? -acc : acc;
    quot_fix   = neg_result ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix    = (is_signed && sign_a) ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      opb          <= '0;
      acc          <= '0;
      counter      <= '0;
      sign_a       <= 1'b0;
      sign_b       <= 1'b0;
      is_div       <= 1'b0;
      is_signed    <= 1'b0;
      b_zero       <= 1'b0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.div_zero <= 1'b0;
      bus.hi       <= '0;
      bus.lo       <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && !bus.abort) begin
            if (!bus.op[2]) begin
              acc       <= {{WIDTH{1'b0}}, a_mag};
              opb       <= b_mag;
              sign_a    <= bus.a[WIDTH-1];
              sign_b    <= bus.b[WIDTH-1];
              is_signed <= req_signed;
              is_div    <= bus.op[1];
              b_zero    <= (bus.b == '0);
              counter   <= '0;
              bus.busy  <= 1'b1;
              state     <= RUN;
            end else if (bus.op == 3'd4) begin
              bus.hi <= bus.a;
            end else if (bus.op == 3'd5) begin
              bus.lo <= bus.a;
            end
          end
        end
        RUN: begin
          if (bus.abort) begin
            bus.busy <= 1'b0;
            state    <= IDLE;
          end else begin
            acc     <= acc_next;
            counter <= counter + CW'(1);
            if (counter == CW'(WIDTH - 1)) state <= FIX;
          end
        end
        FIX: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
          if (!bus.abort) begin
            bus.done <= 1'b1;
            if (is_div) begin
              if (b_zero) begin
                bus.div_zero <= 1'b1;
              end else begin
                bus.div_zero <= 1'b0;
                bus.hi       <= rem_fix;
                bus.lo       <= quot_fix;
              end
            end else begin
              bus.hi <= prod_fix[2*WIDTH-1:WIDTH];
              bus.lo <= prod_fix[WIDTH-1:0];
            end
          end
        end
        default: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - scoreboard bench for muldiv_seq with an arithmetic reference model
module tb_muldiv_seq;
  localparam int W = 32;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           cyc;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   failures;
  int   kk;
  exp_t sb[$];

  logic [W-1:0] mhi;
  logic [W-1:0] mlo;
  logic         mdz;

  muldiv_seq_if #(.WIDTH(W)) m ();

  muldiv_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (m.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && m.done) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: got done=1 expected no pending result (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          chk("done_hi", m.hi, e.hi);
          chk("done_lo", m.lo, e.lo);
          chk("done_div_zero", m.div_zero, e.dz);
          chk("done_cycle", cyc, e.cyc);
        end
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit commit, output int k);
    exp_t        e;
    logic [63:0] p;
    longint      q;
    longint      r;
    m.start = 1'b1;
    m.op    = op;
    m.a     = a;
    m.b     = b;
    @(posedge clk);
    #1;
    k       = cyc;
    m.start = 1'b0;
    m.a     = $urandom;
    m.b     = $urandom;
    m.op    = 3'($urandom_range(0, 7));
    if (commit) begin
      case (op)
        3'd0: begin
          p = longint'($signed(a)) * longint'($signed(b));
          mhi = p[63:32];
          mlo = p[31:0];
        end
        3'd1: begin
          p = {32'd0, a} * {32'd0, b};
          mhi = p[63:32];
          mlo = p[31:0];
        end
        3'd2: begin
          if (b == 0) mdz = 1'b1;
          else begin
            q = longint'($signed(a)) / longint'($signed(b));
            r = longint'($signed(a)) % longint'($signed(b));
            mlo = q[31:0];
            mhi = r[31:0];
            mdz = 1'b0;
          end
        end
        3'd3: begin
          if (b == 0) mdz = 1'b1;
          else begin
            mlo = a / b;
            mhi = a % b;
            mdz = 1'b0;
          end
        end
        3'd4: mhi = a;
        3'd5: mlo = a;
        default: ;
      endcase
      if (op < 3'd4) begin
        e.hi  = mhi;
        e.lo  = mlo;
        e.dz  = mdz;
        e.cyc = k + W + 1;
        sb.push_back(e);
      end
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((m.busy || sb.size() != 0) && n < 200);
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL wait_idle_timeout: got busy=%0b pending=%0d expected idle", m.busy, sb.size());
      sb.delete();
    end
  endtask

  task automatic expect_hl(input string name, input logic [W-1:0] h, input logic [W-1:0] l);
    chk({name, "_hi"}, m.hi, h);
    chk({name, "_lo"}, m.lo, l);
  endtask

  initial begin
    int d;
    int n;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    checks = 0;
    failures = 0;
    mhi = '0;
    mlo = '0;
    mdz = 1'b0;
    reset = 1'b1;
    m.start = 1'b0;
    m.op = 3'd0;
    m.a = '0;
    m.b = '0;
    m.abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", m.busy, 0);
    chk("reset_done", m.done, 0);
    chk("reset_div_zero", m.div_zero, 0);
    expect_hl("reset", 0, 0);
    reset = 1'b0;
    @(negedge clk);

    issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, kk);
    chk("busy_first_cycle", m.busy, 1);
    repeat (W) begin @(posedge clk); #1; end
    chk("busy_last_cycle", m.busy, 1);
    chk("no_early_done", m.done, 0);
    @(posedge clk); #1;
    chk("busy_cleared", m.busy, 0);
    chk("done_pulse", m.done, 1);
    @(posedge clk); #1;
    chk("done_one_cycle", m.done, 0);
    wait_idle();
    expect_hl("multu_max", 32'hFFFFFFFE, 32'h00000001);

    issue(3'd0, 32'hFFFFFFFD, 32'd7, 1, kk);
    wait_idle();
    expect_hl("mult_neg", 32'hFFFFFFFF, 32'hFFFFFFEB);
    issue(3'd0, 32'h80000000, 32'h80000000, 1, kk);
    wait_idle();
    expect_hl("mult_min", 32'h40000000, 32'h0);

    issue(3'd2, 32'hFFFFFFF9, 32'd2, 1, kk);
    wait_idle();
    expect_hl("div_neg", 32'hFFFFFFFF, 32'hFFFFFFFD);
    issue(3'd3, 32'd100, 32'd7, 1, kk);
    wait_idle();
    expect_hl("divu_100_7", 32'd2, 32'd14);
    issue(3'd2, 32'h80000000, 32'hFFFFFFFF, 1, kk);
    wait_idle();
    expect_hl("div_overflow", 32'h0, 32'h80000000);
    chk("div_overflow_flag", m.div_zero, 0);

    issue(3'd4, 32'h12345678, 32'h0, 1, kk);
    chk("mthi_busy", m.busy, 0);
    chk("mthi_hi", m.hi, 32'h12345678);
    issue(3'd3, 32'd5, 32'd0, 1, kk);
    wait_idle();
    chk("divz_flag", m.div_zero, 1);
    chk("divz_hi_kept", m.hi, 32'h12345678);
    issue(3'd3, 32'd9, 32'd3, 1, kk);
    wait_idle();
    chk("divz_cleared", m.div_zero, 0);
    expect_hl("divu_9_3", 32'd0, 32'd3);

    issue(3'd1, 32'd3, 32'd4, 1, kk);
    repeat (9) begin @(posedge clk); #1; end
    m.start = 1'b1;
    m.op = 3'd3;
    m.a = 32'd50;
    m.b = 32'd5;
    @(posedge clk); #1;
    m.start = 1'b0;
    wait_idle();
    expect_hl("busy_start_ignored", 32'd0, 32'd12);
    repeat (40) @(negedge clk);
    chk("ignored_start_no_run", m.busy, 0);

    issue(3'd2, 32'd1000, 32'd7, 0, kk);
    repeat (14) begin @(posedge clk); #1; end
    m.abort = 1'b1;
    @(posedge clk); #1;
    m.abort = 1'b0;
    chk("abort_busy", m.busy, 0);
    chk("abort_done", m.done, 0);
    expect_hl("abort", mhi, mlo);
    repeat (40) @(negedge clk);
    expect_hl("abort_later", mhi, mlo);

    m.start = 1'b1;
    m.op = 3'd4;
    m.a = 32'hDEADBEEF;
    m.abort = 1'b1;
    @(posedge clk); #1;
    m.start = 1'b0;
    m.abort = 1'b0;
    chk("idle_abort_drops_start", m.hi, mhi);

    issue(3'd0, 32'hFFFF1234, 32'h00005678, 0, kk);
    repeat (19) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midreset_busy", m.busy, 0);
    chk("midreset_done", m.done, 0);
    chk("midreset_div_zero", m.div_zero, 0);
    expect_hl("midreset", 0, 0);
    mhi = '0;
    mlo = '0;
    mdz = 1'b0;
    repeat (40) @(negedge clk);
    chk("midreset_stays_idle", m.busy, 0);

    issue(3'd1, $urandom, $urandom, 1, kk);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!m.done && n < 100);
    d = cyc;
    chk("b2b_first_done_seen", m.done, 1);
    issue(3'd3, $urandom, 32'($urandom_range(1, 1000)), 1, kk);
    chk("b2b_accept_cycle", kk, d + 1);
    chk("b2b_busy", m.busy, 1);
    wait_idle();

    repeat (60) begin
      op = 3'($urandom_range(0, 7));
      a = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: b = 32'($urandom_range(1, 15));
        2: b = 32'hFFFFFFFF;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 5) == 0) a = 32'h80000000;
      issue(op, a, b, 1, kk);
      if (op >= 3'd4) begin
        chk("rand_idle_busy", m.busy, 0);
        expect_hl("rand_move", mhi, mlo);
      end
      wait_idle();
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    expect_hl("rand_final", mhi, mlo);
    chk("rand_final_div_zero", m.div_zero, mdz);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected finish within time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
